size_down_fifo_ctrl: RTL
========================

# size_down_fifo_ctrl

Single-clock width-down-converting FIFO built around the team's distributed SDPRAM. A write port accepts WR_WIDTH-bit words and a read port emits RATIO narrow slices per word, least-significant slice first. The block owns the write/read pointers, the full/empty/level flags and the slice sequencer. It sits between a wide producer (e.g. a bus-width datapath) and a narrow consumer (e.g. a byte-serial link).

## Interface
Parameters:
- ADDR_WIDTH, 4: RAM address width; depth = 2**ADDR_WIDTH words; range 4-10.
- WR_WIDTH, 32: write word width; must be divisible by RATIO.
- RATIO, 4: slices per word; power of 2, range 2-16.
- RD_WIDTH, WR_WIDTH/RATIO: derived slice width; not to be overridden.

Ports:
- wr_clk  in  1  sole clock; drives both RAM write and read sides.
- asyn_rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous clear of the FIFO state.
- wr_valid  in  1  producer has a word.
- wr_ready  out  1  FIFO accepts a word (= !full).
- wr_data  in  WR_WIDTH  word to store.
- rd_valid  out  1  a slice is presented (= !empty).
- rd_ready  in  1  consumer takes the slice.
- rd_data  out  RD_WIDTH  current slice; forced to 0 when rd_valid=0.
- full  out  1  level == 2**ADDR_WIDTH.
- empty  out  1  level == 0.
- level  out  ADDR_WIDTH+1  stored words, including a partially read head word.

## Operation
- Pointers wr_ptr and rd_ptr are ADDR_WIDTH+1 bits wide. The low ADDR_WIDTH bits address the RAM; the MSB is the wrap bit.
- empty = (wr_ptr == rd_ptr).
- full = (addresses equal && wrap bits differ).
- level = wr_ptr - rd_ptr, modulo 2**(ADDR_WIDTH+1).
- Push = wr_valid && wr_ready:
  - RAM write at address wr_ptr[ADDR_WIDTH-1:0].
  - wr_ptr increments.
- Slice counter slice_idx is log2(RATIO) bits wide.
- rd_data = RAM[rd_ptr addr][slice_idx*RD_WIDTH +: RD_WIDTH]. This is the combinational RAM read output with OUT_REG=0, i.e. show-ahead.
- Take = rd_valid && rd_ready:
  - If slice_idx < RATIO-1: slice_idx increments.
  - Otherwise: slice_idx returns to 0 and rd_ptr increments (pop).
- Head-word state machine:
  - IDLE (empty).
  - HEAD (slice_idx==0, word present).
  - PARTIAL (slice_idx>0).
  - Transitions:
    - IDLE->HEAD on push.
    - HEAD->PARTIAL on take.
    - PARTIAL->HEAD on the last take when level>1 (or when a push coincides).
    - PARTIAL->IDLE on the last take when level==1 and no push.
  - The state may be derived from slice_idx and empty.
- Simultaneous push and pop:
  - Both take effect in the same cycle; level is unchanged.
  - When full, wr_ready=0 even if a pop occurs in the same cycle. No write-through.
- Wrap-around: the pointer addresses wrap naturally modulo the depth, and the MSB toggles on each wrap.
- flush has priority over push and take in the same cycle. It zeroes wr_ptr, rd_ptr and slice_idx. RAM contents are untouched.
- Reset mid-operation clears all state asynchronously; any partially read word is discarded. RAM contents are not reset.

## Timing
- Reset values:
  - wr_ptr=0, rd_ptr=0, slice_idx=0.
  - empty=1, full=0, level=0.
  - wr_ready=1, rd_valid=0, rd_data=0.
- A push at edge N makes rd_valid=1 in the cycle after edge N, with the data valid in that same cycle. Write-to-read latency is 1 cycle.
- The first slice of a word is the one whose take is qualified at edge M. The next slice appears after edge M with no bubble, giving full throughput of 1 slice per cycle.
- flags and level update only on wr_clk edges (registered pointers). rd_data is combinational from the registered rd_ptr/slice_idx and the RAM.
- All outputs except rd_data are glitch-free functions of registers.

## Structure
- Package size_down_fifo_pkg holds:
  - the clog2 function;
  - derived constants (SLICE_IDX_W, PTR_W);
  - the head-state enum (IDLE, HEAD, PARTIAL).
- Sub-module: one ipm_distributed_sdpram_v1_2_size_down_fifo instance, configured as:
  - ADDR_WIDTH passed through, DATA_WIDTH=WR_WIDTH;
  - OUT_REG=0, RST_TYPE="ASYNC";
  - rd_clk and wr_clk both tied to wr_clk, rst tied to asyn_rst.
- Pointer/flag logic and the slice mux stay in size_down_fifo_ctrl.

## Test plan
All scenarios use ADDR_WIDTH=4, WR_WIDTH=32, RATIO=4.
- Push 0x44332211 with rd_ready=0 -> next cycle rd_valid=1, level=1, rd_data=0x11. Then hold rd_ready=1 -> slices 0x11, 0x22, 0x33, 0x44 on consecutive cycles, then empty=1 and rd_data=0.
- Push 16 words with rd_ready=0 -> full=1, level=16, wr_ready=0. A 17th wr_valid is ignored and level stays 16.
- Stream with wr_valid=1 for one cycle in every 4 and rd_ready=1 continuously, for 40 words (pointers wrap twice) -> byte sequence exactly matches pushed words LSB-first, with no drops or duplicates.
- While full, take the last slice of the head word in the same cycle as wr_valid=1 -> pop occurs, no push, level=15; push succeeds next cycle.
- With 5 words stored and slice_idx=2, assert flush together with wr_valid and rd_ready -> next cycle level=0, empty=1, slice_idx=0, and nothing is written.
- Assert asyn_rst between edges mid-stream (level=7, slice_idx=3) -> outputs go to their reset values immediately, without waiting for an edge. After release, a push of 0xA5A5A5A5 yields 0xA5 first.

Source files
------------

// File: rtl/size_down_fifo_pkg.sv
// size_down_fifo_pkg
//   Shared definitions for the width-down-converting FIFO controller:
//   - clog2: constant function used to size the slice counter.
//   - Derived widths for the default configuration (4-bit address,
//     32-bit write word, 4 slices per word).
//   - head_state_e: head-word sequencing state (IDLE / HEAD / PARTIAL).
package size_down_fifo_pkg;

  // Smallest n such that 2**n >= value; clog2(1) is 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  localparam int DEFAULT_ADDR_WIDTH = 4;
  localparam int DEFAULT_WR_WIDTH   = 32;
  localparam int DEFAULT_RATIO      = 4;

  localparam int SLICE_IDX_W = clog2(DEFAULT_RATIO);
  localparam int PTR_W       = DEFAULT_ADDR_WIDTH + 1;

  // IDLE: nothing stored. HEAD: head word present, no slice taken yet.
  // PARTIAL: at least one slice of the head word already consumed.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEAD    = 2'd1,
    PARTIAL = 2'd2
  } head_state_e;

endpackage

// File: rtl/ipm_distributed_sdpram_v1_2_size_down_fifo.sv
// ipm_distributed_sdpram_v1_2_size_down_fifo
//   Distributed simple-dual-port RAM: one synchronous write port, one read
//   port that is either combinational (OUT_REG=0, show-ahead) or registered
//   (OUT_REG=1). Memory contents are never reset; only the optional output
//   register is, with RST_TYPE selecting "ASYNC" or "SYNC" reset.
// Ports:
//   wr_clk   write clock
//   rd_clk   read clock (only used for the output register)
//   rst      active-high reset of the output register
//   wr_en    write strobe
//   wr_addr  write address
//   wr_data  write data
//   rd_addr  read address
//   rd_data  read data
module ipm_distributed_sdpram_v1_2_size_down_fifo #(
  parameter int    ADDR_WIDTH = 4,
  parameter int    DATA_WIDTH = 32,
  parameter int    OUT_REG    = 0,
  parameter string RST_TYPE   = "ASYNC"
) (
  input  logic                  wr_clk,
  input  logic                  rd_clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge wr_clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  if (OUT_REG == 0) begin : g_comb_out
    // Read clock and reset only matter when the output is registered.
    logic unused_rd_side;
    assign unused_rd_side = rd_clk ^ rst;
    assign rd_data = mem[rd_addr];
  end else if (RST_TYPE == "ASYNC") begin : g_reg_async
    always_ff @(posedge rd_clk or posedge rst) begin
      if (rst) begin
        rd_data <= '0;
      end else begin
        rd_data <= mem[rd_addr];
      end
    end
  end else begin : g_reg_sync
    always_ff @(posedge rd_clk) begin
      if (rst) begin
        rd_data <= '0;
      end else begin
        rd_data <= mem[rd_addr];
      end
    end
  end

endmodule

// File: rtl/size_down_fifo_ctrl.sv
// size_down_fifo_ctrl
//   Single-clock FIFO that stores WR_WIDTH-bit words and emits them as
//   RATIO slices of RD_WIDTH bits, least-significant slice first, with a
//   show-ahead read (the current slice is visible while rd_valid is high).
// Ports:
//   wr_clk    sole clock
//   asyn_rst  asynchronous active-high reset
//   flush     synchronous clear of pointers and slice counter
//   wr_valid / wr_ready / wr_data   wide write handshake
//   rd_valid / rd_ready / rd_data   narrow read handshake (rd_data=0 when idle)
//   full, empty, level              occupancy in words (partial head counts)
module size_down_fifo_ctrl
  import size_down_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int WR_WIDTH   = 32,
  parameter int RATIO      = 4,
  parameter int RD_WIDTH   = WR_WIDTH / RATIO
) (
  input  logic                  wr_clk,
  input  logic                  asyn_rst,
  input  logic                  flush,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [WR_WIDTH-1:0]   wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [RD_WIDTH-1:0]   rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   level
);

  localparam int IDX_W = clog2(RATIO);
  localparam logic [IDX_W-1:0]    LAST_SLICE = IDX_W'(RATIO - 1);
  localparam logic [IDX_W-1:0]    IDX_ONE    = IDX_W'(1);
  localparam logic [ADDR_WIDTH:0] PTR_ONE    = (ADDR_WIDTH + 1)'(1);

  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] wr_ptr_next;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic [ADDR_WIDTH:0] rd_ptr_next;
  logic [IDX_W-1:0]    slice_idx;
  logic [IDX_W-1:0]    slice_idx_next;
  head_state_e         head_state;
  head_state_e         head_state_next;

  logic                push;
  logic                take;
  logic                pop;
  logic [WR_WIDTH-1:0] ram_rd_data;
  logic [RD_WIDTH-1:0] slices [RATIO];

  // Flags come straight from the registered pointers; the extra wrap bit
  // tells a full FIFO apart from an empty one when the addresses match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                    (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
  assign level    = wr_ptr - rd_ptr;
  assign wr_ready = !full;
  assign rd_valid = (head_state != IDLE);

  // A pop in the same cycle never frees space for a push while full.
  assign push = wr_valid && !full;
  assign take = rd_valid && rd_ready;
  assign pop  = take && (slice_idx == LAST_SLICE);

  always_ff @(posedge wr_clk or posedge asyn_rst) begin
    if (asyn_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      slice_idx  <= '0;
      head_state <= IDLE;
    end else begin
      wr_ptr     <= wr_ptr_next;
      rd_ptr     <= rd_ptr_next;
      slice_idx  <= slice_idx_next;
      head_state <= head_state_next;
    end
  end

  // Next pointers, slice counter and head state. Flush overrides any
  // push or take presented in the same cycle.
  always_comb begin
    wr_ptr_next     = wr_ptr;
    rd_ptr_next     = rd_ptr;
    slice_idx_next  = slice_idx;
    head_state_next = head_state;

    if (flush) begin
      wr_ptr_next     = '0;
      rd_ptr_next     = '0;
      slice_idx_next  = '0;
      head_state_next = IDLE;
    end else begin
      if (push) begin
        wr_ptr_next = wr_ptr + PTR_ONE;
      end
      if (take) begin
        if (slice_idx == LAST_SLICE) begin
          slice_idx_next = '0;
          rd_ptr_next    = rd_ptr + PTR_ONE;
        end else begin
          slice_idx_next = slice_idx + IDX_ONE;
        end
      end

      case (head_state)
        IDLE: begin
          if (push) begin
            head_state_next = HEAD;
          end
        end
        HEAD: begin
          if (take) begin
            head_state_next = PARTIAL;
          end
        end
        PARTIAL: begin
          // Finishing the head word leaves a fresh head only if another
          // word is stored or one arrives in the same cycle.
          if (pop) begin
            head_state_next = ((level > PTR_ONE) || push) ? HEAD : IDLE;
          end
        end
        default: begin
          head_state_next = IDLE;
        end
      endcase
    end
  end

  ipm_distributed_sdpram_v1_2_size_down_fifo #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (WR_WIDTH),
    .OUT_REG    (0),
    .RST_TYPE   ("ASYNC")
  ) u_ram (
    .wr_clk  (wr_clk),
    .rd_clk  (wr_clk),
    .rst     (asyn_rst),
    .wr_en   (push && !flush),
    .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data (wr_data),
    .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
    .rd_data (ram_rd_data)
  );

  for (genvar g = 0; g < RATIO; g++) begin : g_slice
    assign slices[g] = ram_rd_data[g*RD_WIDTH +: RD_WIDTH];
  end

  assign rd_data = rd_valid ? slices[slice_idx] : '0;

endmodule
